// File: rtl/m2_iso_bridge_pkg.sv
// m2_bridge_pkg: shared FSM encoding and parameter defaults/ranges for the isolation bridge.
package m2_bridge_pkg;

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_ISOLATED, S_RESUME} bridge_state_e;

    localparam logic [1:0] ST_RUN      = S_RUN;
    localparam logic [1:0] ST_DRAIN    = S_DRAIN;
    localparam logic [1:0] ST_ISOLATED = S_ISOLATED;
    localparam logic [1:0] ST_RESUME   = S_RESUME;

    localparam int NUM_CH_DEF     = 4;
    localparam int NUM_CH_MIN     = 1;
    localparam int NUM_CH_MAX     = 16;
    localparam int PIPE_DEPTH_DEF = 1;
    localparam int PIPE_DEPTH_MIN = 1;
    localparam int PIPE_DEPTH_MAX = 8;
    localparam int CNT_W_DEF      = 8;
    localparam int CNT_W_MIN      = 2;
    localparam int CNT_W_MAX      = 16;

    // wide enough to count up to PIPE_DEPTH_MAX-1
    localparam int DRAIN_W = 4;

endpackage

// File: rtl/m2_iso_bridge_if.sv
// m2_iso_bridge_if: upstream ready / downstream execute bus plus isolation and counter signals.
interface m2_iso_bridge_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
);
    logic                    isolate_req;
    logic                    cnt_clr;
    logic [NUM_CH-1:0]       ready_i;
    logic [NUM_CH-1:0]       execute_o;
    logic                    isolate_ack;
    logic [NUM_CH*CNT_W-1:0] exec_cnt;

    modport master (
        output isolate_req, cnt_clr, ready_i,
        input  execute_o, isolate_ack, exec_cnt
    );

    modport slave (
        input  isolate_req, cnt_clr, ready_i,
        output execute_o, isolate_ack, exec_cnt
    );
endinterface

// File: rtl/m2_iso_bridge_ch_pipe.sv
// m2_ch_pipe: one channel's ready->execute shift register and saturating execute counter.
module m2_ch_pipe #(
    parameter int PIPE_DEPTH = 1,
    parameter int CNT_W      = 8
) (
    input  logic             ck,
    input  logic             arst,
    input  logic             cnt_clr,
    input  logic             din,
    output logic             dout,
    output logic [CNT_W-1:0] cnt
);
    logic [PIPE_DEPTH-1:0] sr;

    assign dout = sr[PIPE_DEPTH-1];

    always_ff @(posedge ck) begin
        if (arst) begin
            sr  <= '0;
            cnt <= '0;
        end else begin
            sr  <= PIPE_DEPTH'({sr, din});
            cnt <= cnt_clr ? '0 : (dout && cnt != '1) ? cnt + CNT_W'(1) : cnt;
        end
    end
endmodule

// File: rtl/m2_iso_bridge.sv
// m2_iso_bridge: per-channel ready->execute pipelines with a shared drain/isolate FSM.
module m2_iso_bridge
    import m2_bridge_pkg::*;
#(
    parameter int NUM_CH     = NUM_CH_DEF,
    parameter int PIPE_DEPTH = PIPE_DEPTH_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input logic ck,
    input logic arst,
    m2_iso_bridge_if.slave bus
);
    logic [1:0]              state, state_nx;
    logic [DRAIN_W-1:0]      drain_cnt;
    logic                    mask;
    logic                    ack;
    logic [NUM_CH-1:0]       stage_in;
    logic [NUM_CH-1:0]       exe;
    logic [NUM_CH*CNT_W-1:0] cnt_all;

    // the request itself masks the sample it arrives with, so nothing new enters once draining starts
    always_comb begin
        mask     = state == ST_RUN ? bus.isolate_req : 1'b1;
        stage_in = bus.ready_i & ~{NUM_CH{mask}};
        state_nx = state == ST_RUN      ? (bus.isolate_req ? ST_DRAIN : ST_RUN)
                 : state == ST_DRAIN    ? (drain_cnt == DRAIN_W'(PIPE_DEPTH - 1) ? ST_ISOLATED : ST_DRAIN)
                 : state == ST_ISOLATED ? (bus.isolate_req ? ST_ISOLATED : ST_RESUME)
                 : ST_RUN;
    end

    always_ff @(posedge ck) begin
        if (arst) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
            ack       <= 1'b0;
        end else begin
            state     <= state_nx;
            drain_cnt <= state == ST_DRAIN ? drain_cnt + DRAIN_W'(1) : '0;
            ack       <= state_nx == ST_ISOLATED;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        m2_ch_pipe #(
            .PIPE_DEPTH(PIPE_DEPTH),
            .CNT_W     (CNT_W)
        ) u_ch (
            .ck     (ck),
            .arst   (arst),
            .cnt_clr(bus.cnt_clr),
            .din    (stage_in[k]),
            .dout   (exe[k]),
            .cnt    (cnt_all[k*CNT_W +: CNT_W])
        );
    end

    assign bus.execute_o   = exe;
    assign bus.isolate_ack = ack;
    assign bus.exec_cnt    = cnt_all;
endmodule

// File: tb/tb_m2_iso_bridge.sv
// tb_m2_iso_bridge: directed checks of pipeline latency, drain/isolate/resume timing, counters and reset.
module tb_m2_iso_bridge;
    logic ck = 1'b0;
    logic arst_a = 1'b1;
    logic arst_b = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 ck = ~ck;

    m2_iso_bridge_if #(.NUM_CH(4), .CNT_W(4)) bus_a ();
    m2_iso_bridge_if #(.NUM_CH(4), .CNT_W(8)) bus_b ();

    m2_iso_bridge #(.NUM_CH(4), .PIPE_DEPTH(3), .CNT_W(4)) u_a (
        .ck  (ck),
        .arst(arst_a),
        .bus (bus_a.slave)
    );

    m2_iso_bridge #(.NUM_CH(4), .PIPE_DEPTH(2), .CNT_W(8)) u_b (
        .ck  (ck),
        .arst(arst_b),
        .bus (bus_b.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge ck);
            #1;
        end
    endtask

    function automatic logic [31:0] cnt_a(input int k);
        return 32'(bus_a.exec_cnt[k*4 +: 4]);
    endfunction

    function automatic logic [31:0] cnt_b(input int k);
        return 32'(bus_b.exec_cnt[k*8 +: 8]);
    endfunction

    initial begin
        bus_a.isolate_req = 1'b0;
        bus_a.cnt_clr     = 1'b0;
        bus_a.ready_i     = '0;
        bus_b.isolate_req = 1'b0;
        bus_b.cnt_clr     = 1'b0;
        bus_b.ready_i     = '0;
        step(2);
        check("a_rst_exe", 32'(bus_a.execute_o), 32'h0);
        check("a_rst_ack", 32'(bus_a.isolate_ack), 32'h0);
        check("a_rst_cnt", 32'(bus_a.exec_cnt), 32'h0);
        check("b_rst_cnt", 32'(bus_b.exec_cnt), 32'h0);
        arst_a = 1'b0;
        step(3);
        // depth-3 latency: single pulse of 0101
        bus_a.ready_i = 4'b0101;
        step(1);
        bus_a.ready_i = 4'b0000;
        check("a_lat_t1", 32'(bus_a.execute_o), 32'h0);
        step(1);
        check("a_lat_t2", 32'(bus_a.execute_o), 32'h0);
        step(1);
        check("a_lat_t3", 32'(bus_a.execute_o), 32'h5);
        step(1);
        check("a_lat_t4", 32'(bus_a.execute_o), 32'h0);
        check("a_cnt0", cnt_a(0), 32'd1);
        check("a_cnt1", cnt_a(1), 32'd0);
        check("a_cnt2", cnt_a(2), 32'd1);
        check("a_cnt3", cnt_a(3), 32'd0);
        // saturation on a 4-bit counter
        bus_a.cnt_clr = 1'b1;
        step(1);
        bus_a.cnt_clr = 1'b0;
        check("a_clr_all", 32'(bus_a.exec_cnt), 32'h0);
        bus_a.ready_i = 4'b0010;
        step(10);
        check("a_cnt1_mid", cnt_a(1), 32'd7);
        step(10);
        check("a_cnt1_sat", cnt_a(1), 32'd15);
        check("a_exe_ch1", 32'(bus_a.execute_o), 32'h2);
        bus_a.cnt_clr = 1'b1;
        step(1);
        bus_a.cnt_clr = 1'b0;
        check("a_clr_pri", cnt_a(1), 32'd0);
        check("a_clr_exe", 32'(bus_a.execute_o), 32'h2);
        step(1);
        check("a_cnt1_re", cnt_a(1), 32'd1);
        check("a_cnt0_idle", cnt_a(0), 32'd0);
        bus_a.ready_i = 4'b0000;

        // depth-2 drain/isolate/resume with all-ones ready held
        arst_b = 1'b0;
        bus_b.ready_i = 4'b1111;
        step(3);
        check("b_run_exe", 32'(bus_b.execute_o), 32'hf);
        bus_b.isolate_req = 1'b1;
        check("b_c20_ack", 32'(bus_b.isolate_ack), 32'h0);
        step(1);
        check("b_c21_exe", 32'(bus_b.execute_o), 32'hf);
        check("b_c21_ack", 32'(bus_b.isolate_ack), 32'h0);
        step(1);
        check("b_c22_exe", 32'(bus_b.execute_o), 32'h0);
        check("b_c22_ack", 32'(bus_b.isolate_ack), 32'h0);
        step(1);
        check("b_c23_ack", 32'(bus_b.isolate_ack), 32'h1);
        check("b_c23_exe", 32'(bus_b.execute_o), 32'h0);
        step(7);
        check("b_c30_ack", 32'(bus_b.isolate_ack), 32'h1);
        check("b_c30_exe", 32'(bus_b.execute_o), 32'h0);
        bus_b.isolate_req = 1'b0;
        step(1);
        check("b_c31_ack", 32'(bus_b.isolate_ack), 32'h0);
        check("b_c31_exe", 32'(bus_b.execute_o), 32'h0);
        step(1);
        check("b_c32_exe", 32'(bus_b.execute_o), 32'h0);
        step(1);
        check("b_c33_exe", 32'(bus_b.execute_o), 32'h0);
        step(1);
        check("b_c34_exe", 32'(bus_b.execute_o), 32'hf);
        check("b_c34_ack", 32'(bus_b.isolate_ack), 32'h0);

        // reset in the second drain cycle
        bus_b.isolate_req = 1'b1;
        step(1);
        check("b_d1_exe", 32'(bus_b.execute_o), 32'hf);
        step(1);
        check("b_d2_exe", 32'(bus_b.execute_o), 32'h0);
        arst_b = 1'b1;
        step(1);
        arst_b = 1'b0;
        bus_b.isolate_req = 1'b0;
        check("b_rr_exe", 32'(bus_b.execute_o), 32'h0);
        check("b_rr_ack", 32'(bus_b.isolate_ack), 32'h0);
        check("b_rr_cnt", 32'(bus_b.exec_cnt), 32'h0);
        step(1);
        check("b_rr1_exe", 32'(bus_b.execute_o), 32'h0);
        check("b_rr1_ack", 32'(bus_b.isolate_ack), 32'h0);
        step(1);
        check("b_rr2_exe", 32'(bus_b.execute_o), 32'hf);
        check("b_rr2_cnt", cnt_b(3), 32'd0);
        step(1);
        check("b_rr3_cnt", cnt_b(3), 32'd1);

        // isolate_req toggling every cycle: period-6 pattern
        bus_b.isolate_req = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            check($sformatf("b_tog_exe%0d", i), 32'(bus_b.execute_o), (i % 6 == 1) ? 32'hf : 32'h0);
            check($sformatf("b_tog_ack%0d", i), 32'(bus_b.isolate_ack), (i % 6 == 3) ? 32'h1 : 32'h0);
            bus_b.isolate_req = (i % 2 == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
